lut_layer_seq: RTL and testbench

LUT_LAYER_SEQ -- requirements
Module: lut_layer_seq

---
 rtl/lut_layer_pkg.sv | 26 ++
 rtl/lut_layer_seq_ram.sv | 24 ++
 rtl/lut_layer_seq.sv | 108 ++++++++++
 tb/tb_lut_layer_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_layer_pkg.sv
// Shared types and sizing helpers for the sequential LUT layer.
// States, default geometry and the index-width function live here so the bench and RTL agree.
package lut_layer_pkg;

  localparam int DEF_NUM_NEURONS = 8;
  localparam int DEF_FAN_IN      = 3;
  localparam int DEF_IN_BITS     = 2;
  localparam int DEF_OUT_BITS    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Neuron index width; a single neuron still needs one address bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int addr_w(input int fan_in, input int in_bits);
    return fan_in * in_bits;
  endfunction

endpackage

// File: rtl/lut_layer_seq_ram.sv
// Table storage: one write port, one registered read port.
// Contents are deliberately not reset; software reloads them.
module lut_table_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 2,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lut_layer_seq.sv
// Time-multiplexed LUT layer: one table read per neuron per cycle through a shared RAM,
// results collected into out_data and held until the consumer takes them.
module lut_layer_seq
  import lut_layer_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int FAN_IN      = DEF_FAN_IN,
  parameter int IN_BITS     = DEF_IN_BITS,
  parameter int OUT_BITS    = DEF_OUT_BITS,
  localparam int ADDR_W     = addr_w(FAN_IN, IN_BITS),
  localparam int IDX_W      = idx_w(NUM_NEURONS),
  localparam int CFG_AW     = IDX_W + ADDR_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_NEURONS*ADDR_W-1:0]   in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  input  logic                            cfg_we,
  input  logic [CFG_AW-1:0]               cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_data,
  output logic                            cfg_err
);

  localparam int               DEPTH  = NUM_NEURONS << ADDR_W;
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(NUM_NEURONS - 1);

  state_t state, state_nxt;

  logic [NUM_NEURONS-1:0][ADDR_W-1:0]   ops;
  logic [NUM_NEURONS-1:0][OUT_BITS-1:0] res;
  logic [IDX_W-1:0]                     k, rd_k;
  logic                                 rd_vld;
  logic                                 in_hs, out_hs, k_last;
  logic [IDX_W-1:0]                     cfg_idx;
  logic                                 cfg_ok;
  logic [CFG_AW-1:0]                    raddr;
  logic [OUT_BITS-1:0]                  rdata;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign k_last    = (k == K_LAST);
  assign out_data  = res;

  // Writes only land between vectors, and only for neurons that exist.
  assign cfg_idx = cfg_addr[CFG_AW-1 -: IDX_W];
  assign cfg_ok  = cfg_we && (state == IDLE) && (int'(cfg_idx) < NUM_NEURONS);
  assign raddr   = {k, ops[k]};

  lut_table_ram #(
    .DEPTH (DEPTH),
    .WIDTH (OUT_BITS),
    .AW    (CFG_AW)
  ) u_ram (
    .clk   (clk),
    .we    (cfg_ok & rst_n),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .re    (state == EVAL),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_hs)  state_nxt = EVAL;
      EVAL:    if (k_last) state_nxt = DRAIN;
      DRAIN:               state_nxt = HOLD;
      HOLD:    if (out_hs) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // rd_vld/rd_k trail the issued read by one cycle to match the RAM latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ops     <= '0;
      k       <= '0;
      rd_k    <= '0;
      rd_vld  <= 1'b0;
      res     <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we & ~cfg_ok;
      rd_vld  <= (state == EVAL);
      rd_k    <= k;
      if (in_hs) begin
        ops <= in_data;
        k   <= '0;
      end else if (state == EVAL) begin
        k <= k_last ? '0 : k + 1'b1;
      end
      if (rd_vld) res[rd_k] <= rdata;
    end
  end

endmodule

// File: tb/tb_lut_layer_seq.sv
// Randomised bench for lut_layer_seq against a table-array reference model.
// A second 5-neuron instance covers out-of-range neuron indices in cfg_addr.
module tb_lut_layer_seq;
  localparam int N   = 8;
  localparam int AW  = 6;
  localparam int OB  = 2;
  localparam int CAW = 9;
  localparam int N5  = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic [N*AW-1:0] in_data;
  logic            in_valid, in_ready;
  logic [N*OB-1:0] out_data;
  logic            out_valid, out_ready;
  logic            cfg_we;
  logic [CAW-1:0]  cfg_addr;
  logic [OB-1:0]   cfg_data;
  logic            cfg_err;

  logic [N5*AW-1:0] b_in_data;
  logic             b_in_valid, b_in_ready;
  logic [N5*OB-1:0] b_out_data;
  logic             b_out_valid, b_out_ready;
  logic             b_cfg_we;
  logic [CAW-1:0]   b_cfg_addr;
  logic [OB-1:0]    b_cfg_data;
  logic             b_cfg_err;

  int checks = 0;
  int errors = 0;
  logic [OB-1:0] tbl [N][64];

  always #5 clk = ~clk;

  lut_layer_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err)
  );

  lut_layer_seq #(.NUM_NEURONS(N5)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr), .cfg_data(b_cfg_data), .cfg_err(b_cfg_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*OB-1:0] model(input logic [N*AW-1:0] v);
    logic [N*OB-1:0] r;
    r = '0;
    for (int n = 0; n < N; n++) r[n*OB +: OB] = tbl[n][v[n*AW +: AW]];
    return r;
  endfunction

  function automatic logic [N*AW-1:0] rand_vec();
    return {$urandom(), $urandom()};
  endfunction

  task automatic cfg_write(input int n, input int e, input logic [OB-1:0] v);
    cfg_we   = 1'b1;
    cfg_addr = CAW'((n << AW) | e);
    cfg_data = v;
    tick();
    cfg_we   = 1'b0;
    tbl[n][e] = v;
  endtask

  // Handshake one vector with out_ready high; report what was observed.
  task automatic run_vec(input logic [N*AW-1:0] v, output int lat, output bit leak,
                         output logic [N*OB-1:0] d, output logic rdy_after);
    in_data   = v;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    lat  = 1;
    leak = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) leak = 1'b1;
      tick();
      lat++;
    end
    d = out_data;
    tick();
    rdy_after = in_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cfg_we = 1'b0;
    in_data = '0; cfg_addr = '0; cfg_data = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_cfg_we = 1'b0;
    b_in_data = '0; b_cfg_addr = '0; b_cfg_data = '0;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %0b want 0", cfg_err); end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [N*AW-1:0] v; int lat; bit leak; logic [N*OB-1:0] d; logic ra;
    cfg_write(0, 0, 2'b10);
    cfg_write(0, 63, 2'b11);
    for (int i = 0; i < 2; i++) begin
      v = rand_vec();
      v[AW-1:0] = (i == 0) ? 6'h00 : 6'h3F;
      run_vec(v, lat, leak, d, ra);
      checks++; if (lat !== 10) begin errors++; $display("FAIL basic_latency%0d got %0d want 10", i, lat); end
      checks++; if (d[OB-1:0] !== tbl[0][v[AW-1:0]]) begin errors++; $display("FAIL basic_slot0_%0d got %b want %b", i, d[OB-1:0], tbl[0][v[AW-1:0]]); end
      checks++; if (leak !== 1'b0) begin errors++; $display("FAIL basic_in_ready_eval%0d got 1 want 0", i); end
      checks++; if (ra !== 1'b1) begin errors++; $display("FAIL basic_in_ready_after%0d got %0b want 1", i, ra); end
    end
  endtask

  task automatic test_random();
    logic [N*AW-1:0] v; int lat; bit leak; logic [N*OB-1:0] d; logic ra;
    for (int n = 0; n < N; n++)
      for (int e = 0; e < 64; e++) cfg_write(n, e, OB'((n ^ e) & 3));
    for (int i = 0; i < 100; i++) begin
      v = rand_vec();
      run_vec(v, lat, leak, d, ra);
      checks++; if (d !== model(v)) begin errors++; $display("FAIL random_data%0d got %h want %h", i, d, model(v)); end
      checks++; if (lat !== 10) begin errors++; $display("FAIL random_latency%0d got %0d want 10", i, lat); end
      checks++; if (leak !== 1'b0) begin errors++; $display("FAIL random_in_ready_eval%0d got 1 want 0", i); end
    end
  endtask

  task automatic test_backpressure();
    logic [N*AW-1:0] v; logic [N*OB-1:0] held; int lat;
    v = rand_vec();
    in_data = v; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_data = ~v;  // still offered; must not be taken while busy
    lat = 1;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    checks++; if (lat !== 10) begin errors++; $display("FAIL bp_latency got %0d want 10", lat); end
    held = out_data;
    checks++; if (held !== model(v)) begin errors++; $display("FAIL bp_data got %h want %h", held, model(v)); end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d got %0b want 1", i, out_valid); end
      checks++; if (out_data !== held) begin errors++; $display("FAIL bp_stable%0d got %h want %h", i, out_data, held); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got %0b want 0", i, in_ready); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle got %0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got %0b want 0", out_valid); end
    checks++; if (out_data !== held) begin errors++; $display("FAIL bp_retain got %h want %h", out_data, held); end
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_capture got %0b want 1", in_ready); end
  endtask

  task automatic test_cfg_in_eval();
    logic [N*AW-1:0] v; logic [OB-1:0] old; int lat; bit leak; logic [N*OB-1:0] d; logic ra;
    v = rand_vec();
    v[AW-1:0] = 6'h15;
    old = tbl[0][6'h15];
    in_data = v; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    cfg_we = 1'b1; cfg_addr = CAW'(6'h15); cfg_data = ~old;
    tick();
    cfg_we = 1'b0;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL eval_cfg_err got %0b want 1", cfg_err); end
    tick();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL eval_cfg_err_pulse got %0b want 0", cfg_err); end
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    checks++; if (out_data !== model(v)) begin errors++; $display("FAIL eval_cfg_data got %h want %h", out_data, model(v)); end
    tick();
    run_vec(v, lat, leak, d, ra);
    checks++; if (d[OB-1:0] !== old) begin errors++; $display("FAIL eval_cfg_unchanged got %b want %b", d[OB-1:0], old); end
    cfg_write(1, 3, tbl[1][3]);
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL idle_cfg_err got %0b want 0", cfg_err); end
  endtask

  task automatic test_bad_index();
    b_cfg_we = 1'b1; b_cfg_addr = {3'd5, 6'd9}; b_cfg_data = 2'b01;
    tick();
    b_cfg_we = 1'b0;
    checks++; if (b_cfg_err !== 1'b1) begin errors++; $display("FAIL badidx5_err got %0b want 1", b_cfg_err); end
    tick();
    checks++; if (b_cfg_err !== 1'b0) begin errors++; $display("FAIL badidx_pulse got %0b want 0", b_cfg_err); end
    b_cfg_we = 1'b1; b_cfg_addr = {3'd7, 6'd0};
    tick();
    b_cfg_we = 1'b0;
    checks++; if (b_cfg_err !== 1'b1) begin errors++; $display("FAIL badidx7_err got %0b want 1", b_cfg_err); end
    b_cfg_we = 1'b1; b_cfg_addr = {3'd4, 6'd0};
    tick();
    b_cfg_we = 1'b0;
    checks++; if (b_cfg_err !== 1'b0) begin errors++; $display("FAIL goodidx4_err got %0b want 0", b_cfg_err); end
  endtask

  task automatic test_reset_mid();
    logic [N*AW-1:0] v; int lat; bit leak; logic [N*OB-1:0] d; logic ra;
    v = rand_vec();
    in_data = v; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rstmid_data got %h want 0", out_data); end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %0b want 1", in_ready); end
    repeat (12) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_output got %0b want 0", out_valid); end
    end
    v = rand_vec();
    run_vec(v, lat, leak, d, ra);
    checks++; if (d !== model(v)) begin errors++; $display("FAIL rstmid_next got %h want %h", d, model(v)); end
    checks++; if (lat !== 10) begin errors++; $display("FAIL rstmid_latency got %0d want 10", lat); end
  endtask

  task automatic test_same_cycle();
    logic [N*AW-1:0] v; int lat; bit leak; logic [N*OB-1:0] d; logic ra;
    v = rand_vec();
    v[2*AW +: AW] = 6'd5;
    cfg_we = 1'b1; cfg_addr = {3'd2, 6'd5}; cfg_data = 2'b01;
    tbl[2][5] = 2'b01;
    run_vec(v, lat, leak, d, ra);
    checks++; if (d[2*OB +: OB] !== 2'b01) begin errors++; $display("FAIL same_slot2 got %b want 01", d[2*OB +: OB]); end
    checks++; if (d !== model(v)) begin errors++; $display("FAIL same_data got %h want %h", d, model(v)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_backpressure();
    test_cfg_in_eval();
    test_bad_index();
    test_reset_mid();
    test_same_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
